twos_to_signmag_serial: RTL and testbench



---
 rtl/twos_to_signmag_serial.sv | 119 +++++++++++
 tb/tb_twos_to_signmag_serial.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's complement to sign-magnitude decoder, LSB first, one bit per clock.
// Rule: copy bits up to and including the first 1, invert every later bit (negative inputs only).
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | in_ready high, waiting for in_valid
// ST_SHIFT | processing one input bit per edge, WIDTH edges
// ST_DONE  | result held on out_*, waiting for out_ready
module twos_to_signmag_serial #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_is_min,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-2:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic             r_seen_one;
  logic             r_out_sign;
  logic [WIDTH-1:0] r_out_mag;
  logic             r_out_is_min;
  logic             w_bit;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_cat;

  // Invert only once a 1 has already passed, and only for negative words.
  assign w_bit  = (r_sign & r_seen_one) ? ~r_shreg[0] : r_shreg[0];
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_cat  = {w_bit, r_work};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_work       <= '0;
      r_cnt        <= '0;
      r_sign       <= 1'b0;
      r_seen_one   <= 1'b0;
      r_out_sign   <= 1'b0;
      r_out_mag    <= '0;
      r_out_is_min <= 1'b0;
    end else if (w_accept) begin
      r_shreg    <= in_data;
      r_work     <= '0;
      r_cnt      <= '0;
      r_sign     <= in_data[WIDTH-1];
      r_seen_one <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_shreg    <= {1'b0, r_shreg[WIDTH-1:1]};
      r_work     <= w_cat[WIDTH-1:1];
      r_cnt      <= r_cnt + 1'b1;
      r_seen_one <= r_seen_one | r_shreg[0];
      if (w_last) begin
        // On the final edge r_seen_one covers exactly the lower WIDTH-1 bits.
        r_out_mag    <= w_cat;
        r_out_sign   <= r_sign;
        r_out_is_min <= r_sign & ~r_seen_one;
      end
    end
  end

  assign out_sign   = r_out_sign;
  assign out_mag    = r_out_mag;
  assign out_is_min = r_out_is_min;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial (WIDTH=6): fixed vectors, backpressure,
// mid-shift reset and a full 64-value sweep against a two's complement reference.
module tb_twos_to_signmag_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [5:0] out_mag;
  logic       out_is_min;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  twos_to_signmag_serial #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_is_min(out_is_min),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic send(input logic [5:0] x);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid, then checks the result.
  task automatic wait_res(input string tag, input logic s, input logic [5:0] m, input logic mn);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd6);
    chk({tag, "_sign"}, 32'(out_sign), 32'(s));
    chk({tag, "_mag"}, 32'(out_mag), 32'(m));
    chk({tag, "_is_min"}, 32'(out_is_min), 32'(mn));
    if (out_ready === 1'b1) begin
      @(negedge clk);
      chk({tag, "_back_idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_back_idle_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] xv;
    logic [5:0] em;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sign", 32'(out_sign), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    chk("rst_out_is_min", 32'(out_is_min), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(6'b000011); wait_res("v000011", 1'b0, 6'b000011, 1'b0);
    send(6'b111100); wait_res("v111100", 1'b1, 6'b000100, 1'b0);
    send(6'b111111); wait_res("v111111", 1'b1, 6'b000001, 1'b0);
    send(6'b000000); wait_res("v000000", 1'b0, 6'b000000, 1'b0);
    send(6'b100000); wait_res("v100000", 1'b1, 6'b100000, 1'b1);
    send(6'b011111); wait_res("v011111", 1'b0, 6'b011111, 1'b0);

    // Backpressure: result held while a new word is offered and ignored.
    out_ready = 1'b0;
    send(6'b111010);
    wait_res("bp111010", 1'b1, 6'b000110, 1'b0);
    in_valid = 1'b1;
    in_data  = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_mag", 32'(out_mag), 32'b000110);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_mag_kept", 32'(out_mag), 32'b000110);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy), 32'd1);
    wait_res("bp000001", 1'b0, 6'b000001, 1'b0);

    // Reset in the middle of SHIFT.
    send(6'b110011);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_mag", 32'(out_mag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_after_busy", 32'(busy), 32'd0);
    send(6'b000101); wait_res("post_rst000101", 1'b0, 6'b000101, 1'b0);

    // Full sweep against sign = x[5], mag = x[5] ? (-x mod 64) : x.
    for (int x = 0; x < 64; x++) begin
      xv = 6'(x);
      em = xv[5] ? 6'(7'd64 - 7'(xv)) : xv;
      send(xv);
      wait_res($sformatf("sweep%0d", x), xv[5], em, (xv == 6'b100000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
